// File: rtl/audio_stream_buffer.sv
// Circular audio sample FIFO: Avalon-MM push side, frame-atomic codec readout.
// Optional macro AUDIO_STREAM_BUFFER_HOLD_EN: underrun frames repeat the last emitted frame.
module audio_stream_buffer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int CHANNELS = 2,
    parameter int LOW_WM   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    input  logic              sample_req,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_channel,
    output logic              irq
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CH_LVL   = (ADDR_W + 1)'(CHANNELS);
    localparam logic [2:0]        LAST_CH  = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ch_q, ch_d;
    logic                sil_q, sil_d;

    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                ovl_q, ovl_d;
    logic                en_q, en_d;
    logic                irq_en_q, irq_en_d;
    logic [15:0]         wm_q, wm_d;
    logic                irq_q;
    logic [31:0]         rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_q;

    logic bus_wr, bus_rd;
    logic wr_data, wr_status, wr_ctrl, wr_wm;
    logic clr, full, empty, busy;
    logic pop, push_req, push;
    logic overflow_evt, underrun_evt, overlap_evt;
    logic [31:0] status_word, rd_mux;

    assign bus_wr    = avs_chipselect & avs_write;
    assign bus_rd    = avs_chipselect & avs_read;
    assign wr_data   = bus_wr && (avs_address == 3'd0);
    assign wr_status = bus_wr && (avs_address == 3'd1);
    assign wr_ctrl   = bus_wr && (avs_address == 3'd2);
    assign wr_wm     = bus_wr && (avs_address == 3'd3);
    assign clr       = wr_ctrl & avs_writedata[1];

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign busy  = (state_q != IDLE);

    // A pop in the same cycle frees a slot, so a push at full is accepted then.
    assign pop          = (state_q == FETCH) && !clr;
    assign push_req     = wr_data && !clr;
    assign push         = push_req && (!full || pop);
    assign overflow_evt = push_req && full && !pop;
    assign underrun_evt = (state_q == IDLE) && sample_req && en_q && (level_q < CH_LVL);
    assign overlap_evt  = sample_req && busy;

`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
    logic              hold_mode_q, hold_mode_d;
    logic [DATA_W-1:0] hold_q [8];
`endif

    // ---------------- readout FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            sil_q       <= 1'b0;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
            hold_mode_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            sil_q       <= sil_d;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
            hold_mode_q <= hold_mode_d;
`endif
        end
    end

    // ---------------- readout FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        sil_d       = sil_q;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
        hold_mode_d = hold_mode_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sample_req) begin
                    ch_d = '0;
                    if (!en_q) begin
                        sil_d   = 1'b1;
                        state_d = EMIT;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
                        hold_mode_d = 1'b0;
`endif
                    end else if (level_q >= CH_LVL) begin
                        sil_d   = 1'b0;
                        state_d = FETCH;
                    end else begin
                        sil_d   = 1'b1;
                        state_d = EMIT;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
                        hold_mode_d = 1'b1;
`endif
                    end
                end
            end
            FETCH: state_d = EMIT;
            EMIT: begin
                if (ch_q == LAST_CH) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + 3'd1;
                    state_d = sil_q ? EMIT : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            ch_d    = '0;
            sil_d   = 1'b0;
        end
    end

    // ---------------- readout FSM: outputs ----------------
    always_comb begin
        out_valid   = (state_q == EMIT) && !sil_q;
        out_channel = (state_q == EMIT) ? ch_q : '0;
        out_data    = '0;
        if (out_valid) begin
            out_data = ram_q;
        end
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
        else if ((state_q == EMIT) && hold_mode_q) begin
            out_data = hold_q[ch_q];
        end
`endif
    end

    // ---------------- pointers, level, registers ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (push && !pop)      level_d = level_q + (ADDR_W + 1)'(1);
        else if (pop && !push) level_d = level_q - (ADDR_W + 1)'(1);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        ovf_d = ovf_q;
        unf_d = unf_q;
        ovl_d = ovl_q;
        if (wr_status && avs_writedata[16]) ovf_d = 1'b0;
        if (wr_status && avs_writedata[17]) unf_d = 1'b0;
        if (wr_status && avs_writedata[21]) ovl_d = 1'b0;
        if (overflow_evt) ovf_d = 1'b1;
        if (underrun_evt) unf_d = 1'b1;
        if (overlap_evt)  ovl_d = 1'b1;

        en_d     = en_q;
        irq_en_d = irq_en_q;
        wm_d     = wm_q;
        if (wr_ctrl) begin
            en_d     = avs_writedata[0];
            irq_en_d = avs_writedata[2];
        end
        if (wr_wm) wm_d = avs_writedata[15:0];
    end

    assign status_word = {10'd0, ovl_q, empty, full, busy, unf_q, ovf_q, 16'(level_q)};

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            3'd1:    rd_mux = status_word;
            3'd2:    rd_mux = {29'd0, irq_en_q, 1'b0, en_q};
            3'd3:    rd_mux = {16'd0, wm_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ovl_q    <= 1'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            wm_q     <= 16'(LOW_WM);
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ovl_q    <= ovl_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            wm_q     <= wm_d;
            irq_q    <= irq_en_q & en_q & (16'(level_q) < wm_q);
            rdata_q  <= bus_rd ? rd_mux : '0;
        end
    end

    // At full, wr_ptr == rd_ptr; read-before-write returns the word being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= avs_writedata[DATA_W-1:0];
        if (pop)  ram_q <= mem[rd_ptr_q];
    end

`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) hold_q[i] <= '0;
        end else if ((state_q == EMIT) && !sil_q) begin
            hold_q[ch_q] <= ram_q;
        end
    end
`endif

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_audio_stream_buffer.sv
// Bench for audio_stream_buffer: directed steps then random traffic against a queue model.
module tb_audio_stream_buffer;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
`ifdef AUDIO_STREAM_BUFFER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    avs_address = '0;
    logic          avs_chipselect = 1'b0;
    logic          avs_write = 1'b0;
    logic          avs_read = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          sample_req = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_channel;
    logic          irq;

    audio_stream_buffer #(
        .DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH), .LOW_WM(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .sample_req(sample_req), .out_valid(out_valid), .out_data(out_data),
        .out_channel(out_channel), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    bit          m_en, m_ie, m_ov, m_un, m_ro;
    int          m_wm;
    logic [31:0] last [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0; m_ie = 0; m_ov = 0; m_un = 0; m_ro = 0;
        m_wm = 1024;
        for (int c = 0; c < CH; c++) last[c] = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_chipselect = 1; avs_write = 1; avs_address = a; avs_writedata = d;
        tick();
        avs_chipselect = 0; avs_write = 0;
        case (a)
            3'd0: if (q.size() == DEPTH) m_ov = 1; else q.push_back(d);
            3'd1: begin
                if (d[16]) m_ov = 0;
                if (d[17]) m_un = 0;
                if (d[21]) m_ro = 0;
            end
            3'd2: begin
                m_en = d[0]; m_ie = d[2];
                if (d[1]) q.delete();
            end
            3'd3: m_wm = int'(d[15:0]);
            default: ;
        endcase
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_chipselect = 1; avs_read = 1; avs_address = a;
        tick();
        avs_chipselect = 0; avs_read = 0;
        d = avs_readdata;
    endtask

    function automatic logic [31:0] exp_status();
        logic [15:0] lvl;
        lvl = 16'(q.size());
        return {10'd0, m_ro, (q.size() == 0), (q.size() == DEPTH), 1'b0, m_un, m_ov, lvl};
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] v;
        rd(3'd1, v);
        chk(tag, v, exp_status());
    endtask

    task automatic check_irq(input string tag);
        tick();
        chk(tag, {31'd0, irq}, {31'd0, m_ie & m_en & (q.size() < m_wm)});
    endtask

    // One frame request; optional DATA push and/or overlapping request in cycle t+1.
    task automatic do_frame(input bit inj, input logic [31:0] inj_d, input bit ovl);
        logic [31:0] ed [CH];
        bit          nrm;
        int          n;
        nrm = 0;
        if (!m_en) begin
            for (int c = 0; c < CH; c++) ed[c] = '0;
        end else if (q.size() >= CH) begin
            nrm = 1;
            for (int c = 0; c < CH; c++) ed[c] = q[c];
        end else begin
            m_un = 1;
            for (int c = 0; c < CH; c++) ed[c] = HOLD ? last[c] : '0;
        end
        sample_req = 1;
        tick();
        sample_req = 0;
        if (inj) begin
            avs_chipselect = 1; avs_write = 1; avs_address = 3'd0; avs_writedata = inj_d;
        end
        if (ovl) sample_req = 1;
        n = nrm ? 2 * CH : CH;
        for (int k = 1; k <= n; k++) begin
            if (nrm) begin
                if (k % 2 == 0) begin
                    chk("frm_valid", {31'd0, out_valid}, 32'd1);
                    chk("frm_data", out_data, ed[k/2-1]);
                    chk("frm_ch", {29'd0, out_channel}, 32'(k/2-1));
                end else begin
                    chk("frm_gap_valid", {31'd0, out_valid}, 32'd0);
                    void'(q.pop_front());
                end
            end else begin
                chk("sil_valid", {31'd0, out_valid}, 32'd0);
                chk("sil_data", out_data, ed[k-1]);
                chk("sil_ch", {29'd0, out_channel}, 32'(k-1));
            end
            if (k == 1) begin
                if (inj) begin
                    if (q.size() == DEPTH) m_ov = 1; else q.push_back(inj_d);
                end
                if (ovl) m_ro = 1;
            end
            tick();
            if (k == 1) begin
                avs_chipselect = 0; avs_write = 0; sample_req = 0;
            end
        end
        if (nrm) for (int c = 0; c < CH; c++) last[c] = ed[c];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] w0;

        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;

        // Reset asserted mid-frame
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h11);
        wr(3'd0, 32'h22);
        sample_req = 1; tick(); sample_req = 0; tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ch", {29'd0, out_channel}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        model_reset();
        rd(3'd1, v); chk("rst_status", v, 32'h0010_0000);
        rd(3'd3, v); chk("rst_wm", v, 32'd1024);
        rd(3'd2, v); chk("rst_ctrl", v, 32'd0);

        // Basic frame
        wr(3'd2, 32'h1);
        wr(3'd0, 32'hA1); wr(3'd0, 32'hB2); wr(3'd0, 32'hC3);
        do_frame(0, '0, 0);
        check_status("after_frame");

        // Underrun at level 1
        do_frame(0, '0, 0);
        check_status("underrun");
        wr(3'd1, 32'h20000);
        check_status("underrun_clr");

        // Fill to full and overflow
        wr(3'd2, 32'h3);
        for (int i = 0; i < 17; i++) wr(3'd0, 32'h100 + 32'(i));
        check_status("full_ovf");
        wr(3'd1, 32'h10000);
        check_status("ovf_clr");

        // Push while popping at full, then drain across the wrap
        do_frame(1, 32'h5A5A, 0);
        check_status("push_pop_full");
        while (q.size() >= CH) do_frame(0, '0, 0);
        check_status("drained");

        // Overlapping request
        wr(3'd2, 32'h3);
        wr(3'd0, 32'h77); wr(3'd0, 32'h88);
        do_frame(0, '0, 1);
        check_status("overlap");
        wr(3'd1, 32'h200000);
        check_status("overlap_clr");

        // Watermark interrupt and clear mid-EMIT
        wr(3'd3, 32'd4);
        wr(3'd2, 32'h5);
        wr(3'd0, 32'h1); wr(3'd0, 32'h2); wr(3'd0, 32'h3);
        check_irq("irq_low");
        wr(3'd0, 32'h4);
        check_irq("irq_high");
        wr(3'd0, 32'h5);
        w0 = q[0];
        sample_req = 1; tick(); sample_req = 0; tick();
        chk("pre_clr_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_clr_data", out_data, w0);
        avs_chipselect = 1; avs_write = 1; avs_address = 3'd2; avs_writedata = 32'h7;
        tick();
        avs_chipselect = 0; avs_write = 0;
        q.delete(); m_en = 1; m_ie = 1;
        last[0] = w0;
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
        check_status("clr_status");
        check_irq("clr_irq");

        // Disabled frame emits zeros with no flag
        wr(3'd0, 32'h99);
        wr(3'd2, 32'h4);
        do_frame(0, '0, 0);
        check_status("disabled");
        rd(3'd5, v); chk("unmapped_rd", v, 32'd0);
        rd(3'd0, v); chk("data_rd", v, 32'd0);
        wr(3'd6, 32'hFFFF_FFFF);
        check_status("unmapped_wr");

        // Random traffic
        wr(3'd2, 32'h1);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3, 4: wr(3'd0, $urandom());
                5, 6, 7:       do_frame(0, '0, 0);
                8:             wr(3'd2, {29'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 3) != 0)});
                9:             check_status("rnd_status");
                10: begin
                    wr(3'd3, 32'($urandom_range(0, 20)));
                    check_irq("rnd_irq");
                end
                default:       wr(3'd1, 32'h230000);
            endcase
        end
        check_status("rnd_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_stream_buffer.md
Name: audio_stream_buffer

Overview:
- Parametrised successor to the fixed 4096x32 audio sample memory.
- Circular sample FIFO over an inferred simple-dual-port RAM. The CPU pushes samples through an Avalon-MM slave; the codec side pulls multi-channel frames on a sample-request strobe.
- Adds occupancy tracking, frame-atomic readout, overflow/underrun flags and a low-watermark interrupt.
- Sits between the Nios II bus and the audio codec serialiser, on a single clock.

Parameters:
- DATA_W, 32, sample word width; 16..32.
- ADDR_W, 12, RAM depth = 2^ADDR_W words; max 15.
- CHANNELS, 2, words per frame, emitted channel 0 first; 1..8.
- LOW_WM, 1024, reset value of the WATERMARK register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word register index
- avs_chipselect  in  1  slave select
- avs_write  in  1  write strobe
- avs_read  in  1  read strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, read latency 1
- sample_req  in  1  one-cycle frame request from codec
- out_valid  out  1  sample word valid
- out_data  out  DATA_W  sample word
- out_channel  out  3  channel index of out_data
- irq  out  1  level-sensitive interrupt

Behaviour:
- Reset: clk and reset_n are the only clock and reset; reset is asynchronous, active-low.
- Output reset values: avs_readdata=0, out_valid=0, out_data=0, out_channel=0, irq=0.
- Internal reset values: wr_ptr=0, rd_ptr=0, level=0, flags=0, CONTROL=0, WATERMARK=LOW_WM.
- Register map (word index):
  - 0 DATA (write only): push writedata[DATA_W-1:0] at wr_ptr.
  - 1 STATUS (read): [15:0]=level; 16=overflow; 17=underrun; 18=busy; 19=full; 20=empty; 21=req_overlap.
  - 1 STATUS (write): writing 1 to bits 16/17/21 clears that bit.
  - 2 CONTROL (r/w): bit0 enable; bit1 clear (self-clearing, reads 0); bit2 irq_en.
  - 3 WATERMARK (r/w): [15:0].
  - Unmapped indices read 0, writes ignored.
- Level arithmetic:
  - level is ADDR_W+1 bits; full when level == 2^ADDR_W.
  - Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
- Push rules:
  - DATA write when full: dropped, pointers unchanged, overflow set.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Readout FSM, states IDLE, FETCH, EMIT; ch counter 0..CHANNELS-1.
  - IDLE + sample_req, enable=1, level>=CHANNELS: go to FETCH with ch=0.
  - IDLE + sample_req, enable=1, level<CHANNELS: underrun set; go to EMIT in silence mode. Pointers and level untouched; the frame is atomic and is never partially consumed.
  - IDLE + sample_req, enable=0: silence frame, no flag.
  - FETCH: RAM read at rd_ptr; rd_ptr+1; level-1; go to EMIT.
  - EMIT: out_valid=1 for one cycle with RAM data, or 0 in silence mode, and out_channel=ch.
  - EMIT exit: if ch==CHANNELS-1 go to IDLE; else ch+1 and go to FETCH (normal) or stay in EMIT (silence).
- Timing:
  - Normal frame: sample_req at cycle t gives words at t+2, t+4, ..., t+2*CHANNELS.
  - Silence frame: words at t+1..t+CHANNELS.
- busy = (state != IDLE). sample_req while busy is ignored and sets req_overlap.
- clear:
  - Same-cycle effect: zero pointers and level; FSM to IDLE; out_valid=0 from the next cycle.
  - Flags and WATERMARK are kept.
  - A DATA write in the same cycle as clear is discarded.
- irq = irq_en & enable & (level < WATERMARK), registered, updated every cycle.
- RAM contents are not reset. Reading STATUS has no side effects.

Optional Feature:
- Macro AUDIO_STREAM_BUFFER_HOLD_EN.
- Defined: the block keeps CHANNELS last-emitted-word registers, reset to 0. Underrun frames repeat the last frame emitted; disable (enable=0) frames still emit zeros.
- Undefined: underrun frames emit zeros, and no hold registers exist.

Test Plan:
- Reset with reset_n low mid-frame -> all outputs 0, STATUS reads 0x00100000 (empty=1), WATERMARK reads 1024.
- CONTROL=1; DATA writes 0xA1, 0xB2, 0xC3; sample_req at t -> out 0xA1/ch0 at t+2, 0xB2/ch1 at t+4, level=1.
- level=1, sample_req -> two silence words at t+1, t+2; underrun=1; level stays 1. With HOLD_EN, the words are 0xA1, 0xB2.
- ADDR_W=4, 17 DATA writes -> level=16, full=1, overflow=1, 17th word lost. Writing 0x10000 to STATUS clears overflow.
- Pop in FETCH coinciding with a DATA write at level=16 -> level stays 16, no overflow, wr_ptr wraps to 1.
- WATERMARK=4, CONTROL=0x5, level=3 -> irq=1 on the next cycle. Write a 4th word -> irq=0. CONTROL bit1 write mid-EMIT -> out_valid=0 next cycle, level=0, irq=1.
